digseg_scan_ctrl: RTL and testbench
===================================

// Module: digseg_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for a multi-digit 7-segment display on the SoC peripheral bus.
//  - Holds one 4-bit hex value per digit and a control register.
//  - Cycles through the digits with a blanking gap between them to avoid ghosting.
//  - Drives the shared segment lines and a one-hot digit select.
//  - Sits behind the bus decoder as a slave; the CPU writes or reads values through ce/we/ack.
// PARAMETERS
//  NUM_DIGITS   4      digits scanned, 2..8
//  SCAN_DIV     50000  clk cycles a digit is lit per visit (>=2)
//  BLANK_CYCS   16     clk cycles all digits are off between visits (>=1)
//  BLINK_DIV    64     scan frames per blink half-period (used only with the macro)
// PORTS
//  clk        in   1           system clock
//  rst        in   1           reset, synchronous, active-high
//  ce_i       in   1           bus chip enable; held until ack_o
//  we_i       in   1           1 = write, 0 = read
//  addr_i     in   4           0..NUM_DIGITS-1 = digit reg; 4'hF = control reg
//  data_i     in   32          write data: digit uses [3:0]; ctrl uses [0]=enable, [15:8]=blank mask, [23:16]=blink mask
//  data_o     out  32          read data, zero-extended, valid while ack_o=1
//  ack_o      out  1           one-cycle transfer acknowledge
//  seg_o      out  7           segments {a,b,c,d,e,f,g}, active-high
//  dig_sel_o  out  NUM_DIGITS  one-hot digit enable, active-high
// BEHAVIOUR
//  Reset values: all outputs 0, digit regs 0, ctrl 0 (display disabled), FSM in IDLE, counters 0.
//  Bus handshake
//   - ce_i=1 with ack_o=0 is sampled at a clock edge. At that edge ack_o goes 1 for exactly one cycle.
//   - A write updates the register at that same edge.
//   - For a read, data_o is loaded at that same edge.
//   - ce_i held high gives one transfer every 2 cycles.
//   - An unmapped address is still acked: the write is ignored and the read returns 0.
//  Scan FSM
//   - IDLE: dig_sel_o=0, seg_o=0. Goes to BLANK when ctrl.enable=1.
//   - BLANK: outputs 0 for BLANK_CYCS cycles. On expiry, loads seg_o from the decode of the
//     digit[idx] register as it was before that edge, sets dig_sel_o=1<<idx, then goes to ON.
//   - ON: holds for SCAN_DIV cycles. Then idx advances, wrapping NUM_DIGITS-1 -> 0, and FSM goes to BLANK.
//   - A digit whose blank-mask bit is 1 shows seg_o=0 but keeps its time slot.
//   - A write to a digit during its own ON slot takes effect at its next visit.
//   - ctrl.enable cleared in any state: at the next edge go to IDLE, zero the outputs, set idx=0.
//   - Counters: width $clog2(max(SCAN_DIV,BLANK_CYCS)+1). They count down to 1, with no wrap beyond the terminal count.
//   - rst mid-scan behaves as full reset, and also cancels a pending ack.
// CONFIGURATION
//  Macro DIGSEG_BLINK_EN
//   - Defined:
//     - A blink-frame counter increments each time idx wraps to 0.
//     - A phase bit toggles every BLINK_DIV frames.
//     - Digits with a blink-mask bit of 1 are blanked while phase=1.
//     - Phase resets to 0 on rst or when the display is disabled.
//   - Undefined: ctrl[23:16] is not stored, reads back 0, and there is no blink logic.
// STRUCTURE
//  defines.v holds:
//   - Segment bus width and digit bus width.
//   - Scan state encodings (IDLE/BLANK/ON).
//   - Control register address 4'hF.
//   - Control field bit positions.
//   - Hex segment patterns 0..F.
//  Sub-module digseg_hex_decode: combinational 4-bit -> 7-segment.
//   - 0=7'b1111110, 1=7'b0110000, 8=7'b1111111, F=7'b1000111.
// TESTING
//  T1 Reset, then write ctrl=1 and digits {3,2,1,0} = {4,3,2,1} with SCAN_DIV=4, BLANK_CYCS=2.
//     -> dig_sel_o cycles 0001,0010,0100,1000; seg_o shows 0110000,1101101,1111001,0110011.
//     -> Each digit is lit 4 cycles and followed by 2 all-zero cycles.
//  T2 Bus handshake: ce_i held high for 3 writes.
//     -> ack_o pulses on cycles 1, 3 and 5.
//     -> Reading addr 2 returns 0x00000003 if 3 was written.
//     -> Reading addr 4'h9 returns 0 with ack.
//  T3 Blank mask 0x02.
//     -> Digit 1 slot shows seg_o=0 while dig_sel_o=0010 is still asserted.
//     -> The other digits are unchanged.
//  T4 Clear ctrl.enable while digit 2 is lit.
//     -> Next cycle outputs are 0. Re-enabling restarts at digit 0 after BLANK_CYCS.
//  T5 Assert rst mid-ON slot.
//     -> All outputs 0 the next cycle. Digit regs read 0.
//  T6 (DIGSEG_BLINK_EN, BLINK_DIV=2) Blink mask 0x01.
//     -> Digit 0 is dark for 2 frames, then lit for 2 frames, repeating. The other digits stay lit.

Source files
------------

// File: rtl/digseg_scan_ctrl_pkg.sv
// Shared widths, scan state encoding, control field positions and hex segment patterns
// for the multiplexed 7-segment scan controller.
package digseg_scan_ctrl_pkg;

  localparam int unsigned SEG_W      = 7;
  localparam int unsigned HEX_W      = 4;
  localparam int unsigned MAX_DIGITS = 8;
  localparam int unsigned BUS_W      = 32;

  localparam logic [3:0] CTRL_ADDR = 4'hF;

  localparam int unsigned CTRL_EN_BIT    = 0;
  localparam int unsigned CTRL_BLANK_LSB = 8;
  localparam int unsigned CTRL_BLINK_LSB = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2
  } scan_state_e;

  // Segment order is {a,b,c,d,e,f,g}, active-high.
  localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

endpackage

// File: rtl/digseg_scan_ctrl_hex_decode.sv
// Combinational 4-bit hex value to 7-segment pattern decoder.
module digseg_hex_decode
  import digseg_scan_ctrl_pkg::*;
(
  input  logic [HEX_W-1:0] hex_i,
  output logic [SEG_W-1:0] seg_o
);

  assign seg_o = HEX_SEG[hex_i];

endmodule

// File: rtl/digseg_scan_ctrl.sv
// Bus-slave scan controller for a multiplexed 7-segment display with inter-digit blanking.
// Optional blink support is compiled in when DIGSEG_BLINK_EN is defined.
module digseg_scan_ctrl
  import digseg_scan_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned BLANK_CYCS = 16,
  parameter int unsigned BLINK_DIV  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce_i,
  input  logic                  we_i,
  input  logic [3:0]            addr_i,
  input  logic [BUS_W-1:0]      data_i,
  output logic [BUS_W-1:0]      data_o,
  output logic                  ack_o,
  output logic [SEG_W-1:0]      seg_o,
  output logic [NUM_DIGITS-1:0] dig_sel_o
);

  localparam int unsigned CNT_MAX = (SCAN_DIV > BLANK_CYCS) ? SCAN_DIV : BLANK_CYCS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] SCAN_LOAD  = CNT_W'(SCAN_DIV);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCS);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

  logic [HEX_W-1:0]      digit_q [NUM_DIGITS];
  logic [HEX_W-1:0]      digit_d [NUM_DIGITS];
  logic                  en_q, en_d;
  logic [MAX_DIGITS-1:0] blankMask_q, blankMask_d;
  logic                  ack_q, ack_d;
  logic [BUS_W-1:0]      rdata_q, rdata_d;

  scan_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;

  logic                  xfer, busWrite, digitHit, ctrlHit;
  logic [IDX_W-1:0]      busIdx;
  logic [MAX_DIGITS-1:0] ctrlBlink;
  logic [BUS_W-1:0]      ctrlWord;
  logic [NUM_DIGITS-1:0] blankLive;
  logic [SEG_W-1:0]      litSeg;
  logic                  blinkDark, darken, frameWrap;

  assign xfer     = ce_i & ~ack_q;
  assign busWrite = xfer & we_i;
  assign digitHit = (addr_i < 4'(NUM_DIGITS));
  assign ctrlHit  = (addr_i == CTRL_ADDR);
  assign busIdx   = addr_i[IDX_W-1:0];
  assign ctrlWord = {8'h00, ctrlBlink, blankMask_q, 7'h00, en_q};

  always_comb begin
    digit_d     = digit_q;
    en_d        = en_q;
    blankMask_d = blankMask_q;
    ack_d       = 1'b0;
    rdata_d     = '0;
    if (xfer) begin
      ack_d = 1'b1;
      if (we_i) begin
        if (digitHit) begin
          digit_d[busIdx] = data_i[HEX_W-1:0];
        end else if (ctrlHit) begin
          en_d        = data_i[CTRL_EN_BIT];
          blankMask_d = data_i[CTRL_BLANK_LSB +: MAX_DIGITS];
        end
      end else begin
        if (digitHit) begin
          rdata_d = BUS_W'(digit_q[busIdx]);
        end else if (ctrlHit) begin
          rdata_d = ctrlWord;
        end
      end
    end
  end

`ifdef DIGSEG_BLINK_EN
  localparam int unsigned        FRAME_W    = $clog2(BLINK_DIV + 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_DIV - 1);

  logic [MAX_DIGITS-1:0] blinkMask_q, blinkMask_d;
  logic [NUM_DIGITS-1:0] blinkLive;
  logic [FRAME_W-1:0]    frame_q, frame_d;
  logic                  phase_q, phase_d;
  logic                  unusedData;

  // Phase flips after every BLINK_DIV completed scan frames and restarts dark-free on disable.
  always_comb begin
    blinkMask_d = blinkMask_q;
    frame_d     = frame_q;
    phase_d     = phase_q;
    if (busWrite && ctrlHit) begin
      blinkMask_d = data_i[CTRL_BLINK_LSB +: MAX_DIGITS];
    end
    if (!en_q) begin
      frame_d = '0;
      phase_d = 1'b0;
    end else if (frameWrap) begin
      if (frame_q == FRAME_LAST) begin
        frame_d = '0;
        phase_d = ~phase_q;
      end else begin
        frame_d = frame_q + FRAME_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blinkMask_q <= '0;
      frame_q     <= '0;
      phase_q     <= 1'b0;
    end else begin
      blinkMask_q <= blinkMask_d;
      frame_q     <= frame_d;
      phase_q     <= phase_d;
    end
  end

  assign blinkLive  = blinkMask_q[NUM_DIGITS-1:0];
  assign blinkDark  = phase_q & blinkLive[idx_q];
  assign ctrlBlink  = blinkMask_q;
  assign unusedData = ^{data_i[31:24], data_i[7:4]};
`else
  logic unusedData;

  assign blinkDark  = 1'b0;
  assign ctrlBlink  = '0;
  assign unusedData = ^{data_i[31:16], data_i[7:4], 32'(BLINK_DIV)};
`endif

  digseg_hex_decode u_decode (
    .hex_i (digit_q[idx_q]),
    .seg_o (litSeg)
  );

  assign blankLive = blankMask_q[NUM_DIGITS-1:0];
  assign darken    = blankLive[idx_q] | blinkDark;
  assign frameWrap = (state_q == ST_ON) && (cnt_q == CNT_LAST) && (idx_q == LAST_IDX);

  // The segment pattern is captured when a slot opens, so mid-slot writes wait for the next visit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    seg_d   = seg_q;
    sel_d   = sel_q;
    if (!en_q) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      seg_d   = '0;
      sel_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          cnt_d   = BLANK_LOAD;
        end
        ST_BLANK: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_ON;
            cnt_d   = SCAN_LOAD;
            sel_d   = NUM_DIGITS'(1) << idx_q;
            seg_d   = darken ? '0 : litSeg;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_ON: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = BLANK_LOAD;
            seg_d   = '0;
            sel_d   = '0;
            idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          seg_d   = '0;
          sel_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digit_q[i] <= '0;
      end
      en_q        <= 1'b0;
      blankMask_q <= '0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      seg_q       <= '0;
      sel_q       <= '0;
    end else begin
      digit_q     <= digit_d;
      en_q        <= en_d;
      blankMask_q <= blankMask_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      seg_q       <= seg_d;
      sel_q       <= sel_d;
    end
  end

  assign data_o    = rdata_q;
  assign ack_o     = ack_q;
  assign seg_o     = seg_q;
  assign dig_sel_o = sel_q;

endmodule

// File: tb/tb_digseg_scan_ctrl.sv
// Self-checking bench for digseg_scan_ctrl: directed bus/scan steps plus random bus traffic,
// compared every cycle against a slot-arithmetic model of the display timeline.
module tb_digseg_scan_ctrl;

  localparam int N      = 4;
  localparam int S      = 4;
  localparam int B      = 2;
  localparam int P      = B + S;
  localparam int FRAME  = N * P;
  localparam int BLINKD = 2;

  localparam logic [6:0] HEX_TB [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  logic        clk;
  logic        rst;
  logic        ce_i;
  logic        we_i;
  logic [3:0]  addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        ack_o;
  logic [6:0]  seg_o;
  logic [N-1:0] dig_sel_o;

  int checks;
  int errors;

  // Reference model: registers as the CPU sees them, plus cycles elapsed since the display started.
  int          run;
  logic [3:0]  mDigit [N];
  logic        mEn;
  logic [7:0]  mBlank;
  logic [7:0]  mBlink;
  logic        mAck;
  logic        mIsRead;
  logic [31:0] mData;
  logic [6:0]  expSeg;
  logic [N-1:0] expSel;

  digseg_scan_ctrl #(
    .NUM_DIGITS (N),
    .SCAN_DIV   (S),
    .BLANK_CYCS (B),
    .BLINK_DIV  (BLINKD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ce_i      (ce_i),
    .we_i      (we_i),
    .addr_i    (addr_i),
    .data_i    (data_i),
    .data_o    (data_o),
    .ack_o     (ack_o),
    .seg_o     (seg_o),
    .dig_sel_o (dig_sel_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic modelEdge();
    int  pos;
    int  slot;
    int  ph;
    int  frame;
    logic dark;
    if (rst) begin
      run = -1;
      for (int i = 0; i < N; i++) mDigit[i] = '0;
      mEn = 1'b0; mBlank = '0; mBlink = '0;
      mAck = 1'b0; mIsRead = 1'b0; mData = '0;
      expSeg = '0; expSel = '0;
      return;
    end
    if (!mEn) begin
      run = -1; expSeg = '0; expSel = '0;
    end else begin
      run++;
      pos  = run % FRAME;
      slot = pos / P;
      ph   = pos % P;
      if (ph < B) begin
        expSeg = '0; expSel = '0;
      end else if (ph == B) begin
        frame  = run / FRAME;
        dark   = mBlank[slot] | (mBlink[slot] & (((frame / BLINKD) % 2) == 1));
        expSel = N'(1) << slot;
        expSeg = dark ? 7'b0 : HEX_TB[mDigit[slot]];
      end
    end
    if (ce_i && !mAck) begin
      mAck = 1'b1; mIsRead = !we_i; mData = '0;
      if (we_i) begin
        if (addr_i < N) mDigit[addr_i] = data_i[3:0];
        else if (addr_i == 4'hF) begin
          mEn = data_i[0];
          mBlank = data_i[15:8];
`ifdef DIGSEG_BLINK_EN
          mBlink = data_i[23:16];
`endif
        end
      end else begin
        if (addr_i < N) mData = {28'b0, mDigit[addr_i]};
        else if (addr_i == 4'hF) mData = {8'b0, mBlink, mBlank, 7'b0, mEn};
      end
    end else begin
      mAck = 1'b0; mIsRead = 1'b0;
    end
  endtask

  task automatic checkOutput();
    checks++;
    assert (ack_o === mAck) else begin
      errors++; $error("[TB] FAIL ack observed=%b expected=%b run=%0d", ack_o, mAck, run);
    end
    checks++;
    assert (seg_o === expSeg) else begin
      errors++; $error("[TB] FAIL seg observed=%b expected=%b run=%0d", seg_o, expSeg, run);
    end
    checks++;
    assert (dig_sel_o === expSel) else begin
      errors++; $error("[TB] FAIL dig_sel observed=%b expected=%b run=%0d", dig_sel_o, expSel, run);
    end
    if (mIsRead) begin
      checks++;
      assert (data_o === mData) else begin
        errors++; $error("[TB] FAIL rdata observed=%h expected=%h", data_o, mData);
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic c, input logic w,
                               input logic [3:0] a, input logic [31:0] d);
    rst = r; ce_i = c; we_i = w; addr_i = a; data_i = d;
    modelEdge();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic busWrite(input logic [3:0] a, input logic [31:0] d);
    applyStimulus(1'b0, 1'b1, 1'b1, a, d);
    idle(1);
  endtask

  initial begin
    logic [5:0]  ackSeen;
    logic [3:0]  ra;
    logic [31:0] rd;
    int unsigned pick;
    int          guard;
    checks = 0;
    errors = 0;
    rst = 1'b1; ce_i = 1'b0; we_i = 1'b0; addr_i = '0; data_i = '0;

    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
    idle(1);

    // Digits {3,2,1,0} = {4,3,2,1}, then enable and watch two full frames.
    for (int i = 0; i < N; i++) busWrite(4'(i), 32'(i + 1));
    busWrite(4'hF, 32'h1);
    idle(2 * FRAME + 4);

    // Chip enable held high across three writes: acks on alternate cycles.
    ackSeen = '0;
    applyStimulus(1'b0, 1'b1, 1'b1, 4'h0, 32'h5); ackSeen[0] = ack_o;
    applyStimulus(1'b0, 1'b1, 1'b1, 4'h1, 32'h6); ackSeen[1] = ack_o;
    applyStimulus(1'b0, 1'b1, 1'b1, 4'h1, 32'h6); ackSeen[2] = ack_o;
    applyStimulus(1'b0, 1'b1, 1'b1, 4'h2, 32'h3); ackSeen[3] = ack_o;
    applyStimulus(1'b0, 1'b1, 1'b1, 4'h2, 32'h3); ackSeen[4] = ack_o;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0); ackSeen[5] = ack_o;
    checks++;
    assert (ackSeen === 6'b010101) else begin
      errors++; $error("[TB] FAIL ack_pattern observed=%b expected=%b", ackSeen, 6'b010101);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h2, 32'h0);
    checks++;
    assert (data_o === 32'h3) else begin
      errors++; $error("[TB] FAIL read_addr2 observed=%h expected=%h", data_o, 32'h3);
    end
    idle(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h9, 32'h0);
    checks++;
    assert (ack_o === 1'b1 && data_o === 32'h0) else begin
      errors++; $error("[TB] FAIL read_unmapped observed=%b/%h expected=1/0", ack_o, data_o);
    end
    idle(1);

    // Blank mask on digit 1 keeps its slot but darkens it.
    busWrite(4'hF, 32'h0000_0201);
    idle(FRAME + 6);
    busWrite(4'hF, 32'h0000_0001);

    // Disable while digit 2 is lit, then re-enable.
    guard = 0;
    while (expSel !== 4'b0100 && guard < 200) begin
      idle(1);
      guard++;
    end
    busWrite(4'hF, 32'h0);
    checks++;
    assert (seg_o === 7'b0 && dig_sel_o === 4'b0) else begin
      errors++; $error("[TB] FAIL disable_outputs observed=%b/%b expected=0/0", seg_o, dig_sel_o);
    end
    busWrite(4'hF, 32'h1);
    idle(FRAME);

    // Reset in the middle of a lit slot clears everything.
    guard = 0;
    while (expSel === '0 && guard < 200) begin
      idle(1);
      guard++;
    end
    idle(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
    for (int i = 0; i < N; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 4'(i), 32'h0);
      idle(1);
    end

`ifdef DIGSEG_BLINK_EN
    for (int i = 0; i < N; i++) busWrite(4'(i), 32'(8 + i));
    busWrite(4'hF, 32'h0001_0001);
    idle(5 * FRAME);
`endif

    // Random bus traffic against the model.
    for (int i = 0; i < 500; i++) begin
      pick = $urandom_range(0, 9);
      rd   = $urandom;
      if (pick < 6) begin
        ra = 4'(pick % N);
      end else if (pick < 8) begin
        ra = 4'hF;
        rd[0] = ($urandom_range(0, 7) != 0);
      end else begin
        ra = 4'($urandom_range(4, 14));
      end
      applyStimulus(1'b0, ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), ra, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
